// File: rtl/arb_pkg.sv
// arb_pkg -- shared definitions for the fetch/data memory-port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, BUSY, RESP)
//   OWN_I/OWN_D : owner encoding (0 = fetch port, 1 = data port)
//   pick_owner  : grant decision for a new transaction in IDLE
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // A lone requester always wins; on a tie the port not served last wins,
  // which yields strict alternation while both ports keep requesting.
  function automatic logic pick_owner(input logic fetch_req,
                                      input logic data_req,
                                      input logic last_owner);
    logic winner;
    if (fetch_req && data_req) begin
      winner = ~last_owner;
    end else if (data_req) begin
      winner = OWN_D;
    end else begin
      winner = OWN_I;
    end
    return winner;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog -- BUSY-phase timeout detector, only instantiated when the
// arbiter is built with ARB_TIMEOUT_EN.
//   clk, rst  : clock and synchronous active-low reset
//   start     : clears the counter (transaction being granted)
//   in_busy   : arbiter is in BUSY this cycle
//   m_ready   : memory completion; a ready on the expiry edge wins
//   expired   : abort the transaction at the coming edge
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_busy,
  input  logic m_ready,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_r;

  // Count BUSY cycles that pass without a memory completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= 8'd0;
    end else if (start) begin
      count_r <= 8'd0;
    end else if (in_busy && !m_ready) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry is gated by m_ready so a completion on the same edge is honoured.
  assign expired = in_busy && !m_ready && (count_r == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one single-ported, variable-latency memory
// between the core's instruction-fetch port (i_*) and load/store port (d_*).
// One transaction at a time: IDLE grants, BUSY holds m_req until m_ready,
// RESP returns a one-cycle ack with read data to the owner.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   i_req/i_addr             fetch request (held until i_ack)
//   i_rdata/i_ack            fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata data request (held until d_ack)
//   d_rdata/d_ack            load data and one-cycle completion pulse
//   m_req/m_we/m_addr/m_wdata registered memory request
//   m_rdata/m_ready          memory read data and completion
//   owner                    0 = fetch, 1 = data; valid while busy
//   busy                     transaction in BUSY or RESP
//   err                      pulses with ack when the transaction was aborted
//
// Build option: define ARB_TIMEOUT_EN to abort a BUSY phase after TIMEOUT
// cycles without m_ready (owner gets ack + err, rdata 0). Without it BUSY
// waits indefinitely and err is constant 0.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              owner,
  output logic              busy,
  output logic              err
);

  import arb_pkg::*;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must lie in 2..255");
  end

  arb_state_e        state_r;
  arb_state_e        state_s;
  logic              last_r;
  logic              last_s;
  logic              grant_s;
  logic              expired_s;

  logic              m_req_s;
  logic              m_we_s;
  logic [ADDR_W-1:0] m_addr_s;
  logic [DATA_W-1:0] m_wdata_s;
  logic [DATA_W-1:0] i_rdata_s;
  logic [DATA_W-1:0] d_rdata_s;
  logic              i_ack_s;
  logic              d_ack_s;
  logic              owner_s;
  logic              busy_s;
  logic              err_s;

`ifdef ARB_TIMEOUT_EN
  logic wd_start_s;
  logic wd_in_busy_s;

  assign wd_start_s   = (state_r == IDLE) && (i_req || d_req);
  assign wd_in_busy_s = (state_r == BUSY);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (wd_start_s),
    .in_busy (wd_in_busy_s),
    .m_ready (m_ready),
    .expired (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  assign grant_s = pick_owner(i_req, d_req, last_r);

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_s   = state_r;
    last_s    = last_r;
    m_req_s   = m_req;
    m_we_s    = m_we;
    m_addr_s  = m_addr;
    m_wdata_s = m_wdata;
    i_rdata_s = i_rdata;
    d_rdata_s = d_rdata;
    owner_s   = owner;
    busy_s    = busy;
    i_ack_s   = 1'b0;
    d_ack_s   = 1'b0;
    err_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (i_req || d_req) begin
          state_s = BUSY;
          m_req_s = 1'b1;
          owner_s = grant_s;
          busy_s  = 1'b1;
          if (grant_s == OWN_D) begin
            m_we_s    = d_we;
            m_addr_s  = d_addr;
            m_wdata_s = d_wdata;
          end else begin
            // Fetches are always reads with no write payload.
            m_we_s    = 1'b0;
            m_addr_s  = i_addr;
            m_wdata_s = {DATA_W{1'b0}};
          end
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end

      BUSY: begin
        if (m_ready) begin
          state_s = RESP;
          m_req_s = 1'b0;
          last_s  = owner;
          if (owner == OWN_D) begin
            d_ack_s = 1'b1;
            // A store leaves the load-data register untouched.
            if (!m_we) begin
              d_rdata_s = m_rdata;
            end else begin
              d_rdata_s = d_rdata;
            end
          end else begin
            i_ack_s   = 1'b1;
            i_rdata_s = m_rdata;
          end
        end else if (expired_s) begin
          state_s = RESP;
          m_req_s = 1'b0;
          last_s  = owner;
          err_s   = 1'b1;
          if (owner == OWN_D) begin
            d_ack_s   = 1'b1;
            d_rdata_s = {DATA_W{1'b0}};
          end else begin
            i_ack_s   = 1'b1;
            i_rdata_s = {DATA_W{1'b0}};
          end
        end else begin
          state_s = BUSY;
        end
      end

      RESP: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = IDLE;
        m_req_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access without an ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      last_r  <= OWN_D;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= {ADDR_W{1'b0}};
      m_wdata <= {DATA_W{1'b0}};
      i_rdata <= {DATA_W{1'b0}};
      d_rdata <= {DATA_W{1'b0}};
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      owner   <= OWN_I;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      m_req   <= m_req_s;
      m_we    <= m_we_s;
      m_addr  <= m_addr_s;
      m_wdata <= m_wdata_s;
      i_rdata <= i_rdata_s;
      d_rdata <= d_rdata_s;
      i_ack   <= i_ack_s;
      d_ack   <= d_ack_s;
      owner   <= owner_s;
      busy    <= busy_s;
      err     <= err_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- self-checking bench for mem_port_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
// The reference model tracks expected rdata per port and the last-served
// port, and predicts grant, memory request fields and ack timing directly
// from the arbitration rules. Timeout scenarios run with ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic          owner;
  logic          busy;
  logic          err;

  int            n_checks;
  int            n_pass;
  logic [DW-1:0] exp_i_rdata;
  logic [DW-1:0] exp_d_rdata;
  logic          exp_last;

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .owner   (owner),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0;
    tick(); tick();
    rst = 1'b1;
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0; exp_last = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; m_ready = 1'b1;
    i_addr = 32'h1234_5678; d_addr = 32'h8765_4321; d_wdata = 32'hFFFF_FFFF;
    m_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    n_checks++;
    if ({m_req, m_we, i_ack, d_ack, owner, busy, err} !== 7'b0)
      $display("FAIL reset_ctrl: got %b required %b",
               {m_req, m_we, i_ack, d_ack, owner, busy, err}, 7'b0);
    else n_pass++;
    n_checks++;
    if ({m_addr, m_wdata} !== 64'h0)
      $display("FAIL reset_m_bus: got %h required %h", {m_addr, m_wdata}, 64'h0);
    else n_pass++;
    n_checks++;
    if ({i_rdata, d_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h required %h", {i_rdata, d_rdata}, 64'h0);
    else n_pass++;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0; exp_last = 1'b1;
    tick();
    n_checks++;
    if ({m_req, busy} !== 2'b00)
      $display("FAIL idle_no_req: got %b required %b", {m_req, busy}, 2'b00);
    else n_pass++;
  endtask

  task automatic test_fetch_alone();
    i_req = 1'b1; i_addr = 32'h0040_0000;
    tick();
    n_checks++;
    if ({m_req, m_we, owner, busy, i_ack, d_ack} !== 6'b100100)
      $display("FAIL fetch_busy_ctrl: got %b required %b",
               {m_req, m_we, owner, busy, i_ack, d_ack}, 6'b100100);
    else n_pass++;
    n_checks++;
    if ({m_addr, m_wdata} !== {32'h0040_0000, 32'h0})
      $display("FAIL fetch_m_bus: got %h required %h", {m_addr, m_wdata},
               {32'h0040_0000, 32'h0});
    else n_pass++;
    m_ready = 1'b1; m_rdata = 32'h00A0_0093;
    tick();
    exp_i_rdata = 32'h00A0_0093; exp_last = 1'b0;
    n_checks++;
    if ({i_ack, d_ack, m_req, err} !== 4'b1000)
      $display("FAIL fetch_ack: got %b required %b", {i_ack, d_ack, m_req, err}, 4'b1000);
    else n_pass++;
    n_checks++;
    if (i_rdata !== exp_i_rdata)
      $display("FAIL fetch_rdata: got %h required %h", i_rdata, exp_i_rdata);
    else n_pass++;
    i_req = 1'b0; m_ready = 1'b0;
    tick();
    n_checks++;
    if ({i_ack, d_ack, busy, m_req} !== 4'b0)
      $display("FAIL fetch_done: got %b required %b", {i_ack, d_ack, busy, m_req}, 4'b0);
    else n_pass++;
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0000; d_wdata = 32'hCAFE_F00D;
    m_ready = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if ({m_req, m_we, owner, i_ack, d_ack, m_addr, m_wdata} !==
          {5'b11100, 32'h1001_0000, 32'hCAFE_F00D})
        $display("FAIL store_busy_%0d: got %h required %h", j,
                 {m_req, m_we, owner, i_ack, d_ack, m_addr, m_wdata},
                 {5'b11100, 32'h1001_0000, 32'hCAFE_F00D});
      else n_pass++;
      m_ready = (j == 3); m_rdata = 32'hDEAD_BEEF;
      tick();
    end
    exp_last = 1'b1;
    n_checks++;
    if ({d_ack, i_ack, err, m_req} !== 4'b1000)
      $display("FAIL store_ack: got %b required %b", {d_ack, i_ack, err, m_req}, 4'b1000);
    else n_pass++;
    n_checks++;
    if (d_rdata !== exp_d_rdata)
      $display("FAIL store_rdata_kept: got %h required %h", d_rdata, exp_d_rdata);
    else n_pass++;
    d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    tick();
    n_checks++;
    if ({d_ack, busy} !== 2'b00)
      $display("FAIL store_single_ack: got %b required %b", {d_ack, busy}, 2'b00);
    else n_pass++;
  endtask

  task automatic test_alternation();
    logic [3:0]    order;
    logic          w;
    logic [DW-1:0] rd;
    order = 4'b1010;
    do_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = $urandom; d_addr = $urandom;
    for (int t = 0; t < 4; t++) begin
      w = order[t];
      tick();
      n_checks++;
      if ({owner, m_req, m_we, m_addr} !== {w, 2'b10, (w ? d_addr : i_addr)})
        $display("FAIL alt_grant_%0d: got %h required %h", t, {owner, m_req, m_we, m_addr},
                 {w, 2'b10, (w ? d_addr : i_addr)});
      else n_pass++;
      m_ready = 1'b1; m_rdata = $urandom; rd = m_rdata;
      tick();
      if (w) exp_d_rdata = rd; else exp_i_rdata = rd;
      exp_last = w;
      n_checks++;
      if ({i_ack, d_ack} !== {~w, w})
        $display("FAIL alt_ack_%0d: got %b required %b", t, {i_ack, d_ack}, {~w, w});
      else n_pass++;
      n_checks++;
      if ({i_rdata, d_rdata} !== {exp_i_rdata, exp_d_rdata})
        $display("FAIL alt_rdata_%0d: got %h required %h", t, {i_rdata, d_rdata},
                 {exp_i_rdata, exp_d_rdata});
      else n_pass++;
      m_ready = 1'b0;
      if (w) d_addr = $urandom; else i_addr = $urandom;
      tick();
      n_checks++;
      if ({i_ack, d_ack, busy} !== 3'b000)
        $display("FAIL alt_idle_%0d: got %b required %b", t, {i_ack, d_ack, busy}, 3'b000);
      else n_pass++;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    logic [DW-1:0] rd;
    d_req = 1'b1; d_we = 1'b0; d_addr = $urandom; m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({m_req, busy, i_ack, d_ack, i_rdata, d_rdata} !== {4'b0, 64'h0})
      $display("FAIL midbusy_reset: got %h required %h",
               {m_req, busy, i_ack, d_ack, i_rdata, d_rdata}, {4'b0, 64'h0});
    else n_pass++;
    rst = 1'b1; d_req = 1'b0;
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0; exp_last = 1'b1;
    tick();
    n_checks++;
    if ({d_ack, i_ack, busy} !== 3'b000)
      $display("FAIL midbusy_no_ack: got %b required %b", {d_ack, i_ack, busy}, 3'b000);
    else n_pass++;
    i_req = 1'b1; i_addr = $urandom;
    tick();
    n_checks++;
    if ({m_req, owner, m_addr} !== {2'b10, i_addr})
      $display("FAIL post_reset_grant: got %h required %h", {m_req, owner, m_addr},
               {2'b10, i_addr});
    else n_pass++;
    m_ready = 1'b1; m_rdata = $urandom; rd = m_rdata;
    tick();
    exp_i_rdata = rd; exp_last = 1'b0;
    n_checks++;
    if ({i_ack, d_ack, i_rdata} !== {2'b10, exp_i_rdata})
      $display("FAIL post_reset_ack: got %h required %h", {i_ack, d_ack, i_rdata},
               {2'b10, exp_i_rdata});
    else n_pass++;
    i_req = 1'b0; m_ready = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic          pend_i;
    logic          pend_d;
    int            cool;
    logic          w;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] rd;
    int            delay;
    pend_i = 1'b0; pend_d = 1'b0; cool = 2; rd = 32'h0;
    for (int it = 0; it < 40; it++) begin
      if (!pend_i && cool != 0 && $urandom_range(0, 1) == 1) begin
        pend_i = 1'b1; i_addr = $urandom;
      end
      if (!pend_d && cool != 1 && $urandom_range(0, 1) == 1) begin
        pend_d = 1'b1; d_addr = $urandom; d_wdata = $urandom;
        d_we = ($urandom_range(0, 1) == 1);
      end
      if (!pend_i && !pend_d) begin
        if (cool == 0) begin
          pend_d = 1'b1; d_addr = $urandom; d_wdata = $urandom;
          d_we = ($urandom_range(0, 1) == 1);
        end else begin
          pend_i = 1'b1; i_addr = $urandom;
        end
      end
      i_req = pend_i; d_req = pend_d;
      m_ready = ($urandom_range(0, 1) == 1);
      m_rdata = $urandom;
      w        = (pend_i && pend_d) ? ~exp_last : pend_d;
      exp_addr = w ? d_addr : i_addr;
      exp_we   = w ? d_we : 1'b0;
      exp_wd   = w ? d_wdata : 32'h0;
      tick();
      delay = $urandom_range(0, 3);
      for (int j = 0; j <= delay; j++) begin
        n_checks++;
        if ({m_req, owner, busy, i_ack, d_ack, m_we, m_addr, m_wdata} !==
            {1'b1, w, 3'b100, exp_we, exp_addr, exp_wd})
          $display("FAIL rand_busy_%0d_%0d: got %h required %h", it, j,
                   {m_req, owner, busy, i_ack, d_ack, m_we, m_addr, m_wdata},
                   {1'b1, w, 3'b100, exp_we, exp_addr, exp_wd});
        else n_pass++;
        m_ready = (j == delay); m_rdata = $urandom;
        if (j == delay) rd = m_rdata;
        tick();
      end
      if (w) begin
        if (!exp_we) exp_d_rdata = rd;
      end else begin
        exp_i_rdata = rd;
      end
      exp_last = w;
      n_checks++;
      if ({i_ack, d_ack, err, m_req, busy, i_rdata, d_rdata} !==
          {~w, w, 3'b001, exp_i_rdata, exp_d_rdata})
        $display("FAIL rand_resp_%0d: got %h required %h", it,
                 {i_ack, d_ack, err, m_req, busy, i_rdata, d_rdata},
                 {~w, w, 3'b001, exp_i_rdata, exp_d_rdata});
      else n_pass++;
      if (w) pend_d = 1'b0; else pend_i = 1'b0;
      i_req = pend_i; d_req = pend_d; cool = w ? 1 : 0;
      m_ready = ($urandom_range(0, 1) == 1);
      tick();
      n_checks++;
      if ({i_ack, d_ack, busy, m_req} !== 4'b0)
        $display("FAIL rand_idle_%0d: got %b required %b", it,
                 {i_ack, d_ack, busy, m_req}, 4'b0);
      else n_pass++;
    end
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0040_0010;
    tick();
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    i_req = 1'b0; m_ready = 1'b0;
    tick();
    i_req = 1'b1; i_addr = 32'h0040_0020;
    tick();
    for (int j = 1; j <= TO; j++) begin
      n_checks++;
      if ({m_req, i_ack, err} !== 3'b100)
        $display("FAIL to_busy_%0d: got %b required %b", j, {m_req, i_ack, err}, 3'b100);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({i_ack, d_ack, err, m_req, i_rdata} !== {4'b1010, 32'h0})
      $display("FAIL to_expire: got %h required %h", {i_ack, d_ack, err, m_req, i_rdata},
               {4'b1010, 32'h0});
    else n_pass++;
    i_req = 1'b0;
    tick();
    n_checks++;
    if ({i_ack, err, busy} !== 3'b000)
      $display("FAIL to_after: got %b required %b", {i_ack, err, busy}, 3'b000);
    else n_pass++;
  endtask

  task automatic test_timeout_race();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0040;
    tick();
    for (int j = 1; j <= TO; j++) begin
      n_checks++;
      if ({m_req, d_ack, err} !== 3'b100)
        $display("FAIL race_busy_%0d: got %b required %b", j, {m_req, d_ack, err}, 3'b100);
      else n_pass++;
      m_ready = (j == TO); m_rdata = 32'hA5A5_0F0F;
      tick();
    end
    n_checks++;
    if ({d_ack, err, m_req, d_rdata} !== {3'b100, 32'hA5A5_0F0F})
      $display("FAIL race_resp: got %h required %h", {d_ack, err, m_req, d_rdata},
               {3'b100, 32'hA5A5_0F0F});
    else n_pass++;
    d_req = 1'b0; m_ready = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish required finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_fetch_alone();
    test_store();
    test_alternation();
    test_reset_mid_busy();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
